line_buffer_reader: RTL and testbench
=====================================

# line_buffer_reader

Read-side controller for the scaler line buffer. The upstream writer fills line slots in a dual-port RAM through port A and pulses `line_written` per completed line. This block owns port B. It tracks how many lines are filled, fetches one line per `start` command as a pixel stream with valid/ready backpressure, and frees the slot once its last pixel is accepted. It sits between the line-buffer RAM and the scaler interpolation datapath.

## Interface
- `DATA_WIDTH`, 8, pixel width; matches RAM data width.
- `PIX_BITS`, 9, log2 pixels per line slot.
- `LINE_BITS`, 2, log2 number of line slots; RAM address width is PIX_BITS+LINE_BITS, address = {slot, pixel}.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous frame restart; same effect as `rst` on all state.
- `line_written`  in  1  one-cycle pulse from writer: one more slot is filled.
- `lb_full`  out  1  all 2**LINE_BITS slots filled; writer must stall.
- `overflow`  out  1  sticky flag, set by `line_written` while `lb_full`.
- `start`  in  1  request to stream the next filled line.
- `line_width`  in  PIX_BITS  pixels to read, sampled with `start`; 0 means 2**PIX_BITS.
- `busy`  out  1  high from accepted `start` until the last pixel is accepted.
- `ram_addr`  out  PIX_BITS+LINE_BITS  port B address.
- `ram_we`  out  1  port B write enable, constant 0.
- `ram_q`  in  DATA_WIDTH  port B read data, valid one cycle after the address.
- `out_valid`  out  1  pixel available.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `out_data`  out  DATA_WIDTH  pixel.
- `out_last`  out  1  marks the final pixel of the line.

## Operation
- Reset/flush values:
  - outputs: `lb_full`=0, `overflow`=0, `busy`=0, `ram_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
  - internal: fill count 0, read slot 0, FSM IDLE, skid FIFO empty, in-flight flag 0.
- Fill count, range 0..2**LINE_BITS:
  - +1 on `line_written`.
  - −1 when a line's last pixel is accepted.
  - Both in the same cycle: count unchanged.
  - `line_written` at full: count unchanged and `overflow` set. If a last-pixel accept happens in the same cycle, the count is not full and the write counts normally.
- `lb_full` = (count == 2**LINE_BITS), registered from the next-state count.
- FSM states: IDLE, WAIT, STREAM.
  - IDLE: `start` latches width (0→2**PIX_BITS), clears the pixel counter, sets `busy`. Go to STREAM if count>0 (including a same-cycle `line_written`), else WAIT.
  - IDLE: `start` while not IDLE is ignored.
  - WAIT: go to STREAM the cycle after count becomes >0.
  - STREAM: issue reads `ram_addr` = {read_slot, pix} while pix < width.
  - STREAM: a read issues when (fifo_count + inflight − pop) ≤ 1, where pop = `out_valid & out_ready`.
  - STREAM: each issue increments pix. `ram_q` is pushed into the 2-entry skid FIFO the next cycle with a tag bit last = (pix == width−1).
  - STREAM exit: when the tagged-last entry is accepted, read_slot increments modulo 2**LINE_BITS, count decrements, `busy` drops, FSM returns to IDLE.
- Throughput: 1 pixel/cycle while `out_ready`=1. No pixel is lost or duplicated under any `out_ready` pattern.
- `out_valid`/`out_data`/`out_last` are driven from FIFO head registers. Once `out_valid` rises, it and `out_data` hold stable until accepted.
- `flush`/`rst` mid-line: in-flight read is discarded, the line is abandoned, and no decrement happens.

## Timing
- `start` sampled at edge 0 with count>0: STREAM in cycle 1, first address in cycle 1, `ram_q` in cycle 2, `out_valid` in cycle 3. Start-to-first-pixel latency is 3 cycles.
- From WAIT: `line_written` at edge k → first `out_valid` in cycle k+3.
- Last accept at edge m: `busy`=0 and the decremented count are visible in cycle m+1. A `start` in cycle m+1 is accepted.
- `lb_full` reflects an event one cycle after it.

## Structure
- Package `video_lb_pkg`: FSM state enum, and helper functions for slot count and address width derived from `PIX_BITS`/`LINE_BITS`.
- Sub-module `lb_skid_fifo`: 2-entry registered FIFO of {last, data} with push/pop/count, parameterized by `DATA_WIDTH`.
- Top level: FSM, counters, address generation, issue condition.

## Test plan
- Basic line:
  - Stimulus: `line_written` once, then `start` with `line_width`=4, `out_ready`=1.
  - Response: `out_valid` in cycle 3, addresses 0..3 on consecutive cycles, `out_last` only on the 4th pixel, count returns to 0.
- Backpressure:
  - Stimulus: width 8, `out_ready` toggling 1,0,0,1,…
  - Response: the 8 pixels match RAM contents in order, with no duplicates; `out_data` stays stable while stalled.
- Wait then wrap:
  - Stimulus: `start` with count 0; `line_written` 5 cycles later; repeat 5 lines with LINE_BITS=2.
  - Response: stream begins 3 cycles after the pulse; slots read 0,1,2,3,0.
- Full/overflow:
  - Stimulus: 4 pulses then a 5th.
  - Response: `lb_full`=1 after the 4th, `overflow`=1 after the 5th, count stays 4.
  - Stimulus: `line_written` on the same cycle as a last accept while full.
  - Response: count stays 4 and `overflow` stays 0.
- Width 0 and flush:
  - Stimulus: `line_width`=0.
  - Response: 512 pixels, last at address {slot,511}.
  - Stimulus: `flush` asserted mid-line.
  - Response: next cycle `out_valid`=0, `busy`=0, count 0, read slot 0.

Source files
------------

// File: rtl/video_lb_pkg.sv
// Shared types and geometry helpers for the scaler line-buffer reader.
package video_lb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StStream
   } lb_state_e;

   function automatic int unsigned lb_slots(input int unsigned line_bits);
      return 32'd1 << line_bits;
   endfunction

   function automatic int unsigned lb_addr_width(input int unsigned pix_bits,
                                                 input int unsigned line_bits);
      return pix_bits + line_bits;
   endfunction

endpackage

// File: rtl/line_buffer_reader_if.sv
// Pixel stream handshake bundle leaving the line-buffer reader.
interface line_buffer_reader_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  valid;
   logic                  ready;
   logic                  last;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/lb_skid_fifo.sv
// Two-entry registered FIFO of {last, data}; the head entry drives the stream outputs directly.
module lb_skid_fifo #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic                  push_last_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic                  head_valid_o,
   output logic                  head_last_o,
   output logic [DATA_WIDTH-1:0] head_data_o,
   output logic [1:0]            count_o
);

   logic [DATA_WIDTH:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]          count_q, count_d;
   logic                do_pop, push_ok;
   logic [DATA_WIDTH:0] push_entry;

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      push_entry = {push_last_i, push_data_i};
      do_pop     = pop_i && (count_q != 2'd0);
      push_ok    = push_i && ((count_q != 2'd2) || do_pop);
      unique case ({push_ok, do_pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = push_entry;
            else                 tail_d = push_entry;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = push_entry;
            end else begin
               head_d = tail_q;
               tail_d = push_entry;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_valid_o = (count_q != 2'd0);
   assign head_last_o  = head_q[DATA_WIDTH];
   assign head_data_o  = head_q[DATA_WIDTH-1:0];
   assign count_o      = count_q;

endmodule

// File: rtl/line_buffer_reader.sv
// Read-side controller for the scaler line buffer: tracks filled slots and streams one line
// per start command from RAM port B through a skid FIFO.
module line_buffer_reader
   import video_lb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PIX_BITS   = 9,
   parameter int unsigned LINE_BITS  = 2,
   localparam int unsigned AddrWidth = lb_addr_width(PIX_BITS, LINE_BITS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic                  line_written_i,
   output logic                  lb_full_o,
   output logic                  overflow_o,
   input  logic                  start_i,
   input  logic [PIX_BITS-1:0]   line_width_i,
   output logic                  busy_o,
   output logic [AddrWidth-1:0]  ram_addr_o,
   output logic                  ram_we_o,
   input  logic [DATA_WIDTH-1:0] ram_q_i,
   line_buffer_reader_if.master  out_io
);

   localparam logic [LINE_BITS:0] FullCount = (LINE_BITS+1)'(lb_slots(LINE_BITS));
   localparam logic [PIX_BITS:0]  MaxWidth  = (PIX_BITS+1)'(lb_slots(PIX_BITS));
   localparam logic [PIX_BITS:0]  PixOne    = (PIX_BITS+1)'(1);

   lb_state_e              state_q, state_d;
   logic [LINE_BITS:0]     count_q, count_d;
   logic [LINE_BITS-1:0]   slot_q, slot_d;
   logic [PIX_BITS:0]      pix_q, pix_d, width_q, width_d;
   logic                   inflight_q, inflight_d, inflight_last_q, inflight_last_d;
   logic                   full_q, ovf_q, ovf_d;

   logic                   fifo_valid, fifo_last;
   logic [DATA_WIDTH-1:0]  fifo_data;
   logic [1:0]             fifo_count;
   logic                   pop, last_accept, issue;
   logic [2:0]             occ;

   assign pop         = fifo_valid && out_io.ready;
   assign last_accept = pop && fifo_last;

   // Keep at most two pixels buffered or in flight after this cycle's pop.
   assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q};
   assign issue = (state_q == StStream) && (pix_q < width_q) && (occ <= 3'd1 + {2'b00, pop});

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case ({line_written_i, last_accept})
         2'b10: begin
            if (count_q == FullCount) ovf_d = 1'b1;
            else                      count_d = count_q + (LINE_BITS+1)'(1);
         end
         2'b01:   count_d = count_q - (LINE_BITS+1)'(1);
         default: ;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      slot_d          = slot_q;
      pix_d           = pix_q;
      width_d         = width_q;
      inflight_d      = issue;
      inflight_last_d = issue && (pix_q == width_q - PixOne);
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               width_d = (line_width_i == '0) ? MaxWidth : {1'b0, line_width_i};
               pix_d   = '0;
               state_d = (count_d != '0) ? StStream : StWait;
            end
         end
         StWait: begin
            if (count_d != '0) state_d = StStream;
         end
         StStream: begin
            if (issue) pix_d = pix_q + PixOne;
            if (last_accept) begin
               state_d = StIdle;
               slot_d  = slot_q + LINE_BITS'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         state_q         <= StIdle;
         count_q         <= '0;
         slot_q          <= '0;
         pix_q           <= '0;
         width_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         full_q          <= 1'b0;
         ovf_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         slot_q          <= slot_d;
         pix_q           <= pix_d;
         width_q         <= width_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         full_q          <= (count_d == FullCount);
         ovf_q           <= ovf_d;
      end
   end

   // Flush also empties the FIFO so an abandoned line leaves nothing behind.
   lb_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i | flush_i),
      .push_i       (inflight_q),
      .push_last_i  (inflight_last_q),
      .push_data_i  (ram_q_i),
      .pop_i        (pop),
      .head_valid_o (fifo_valid),
      .head_last_o  (fifo_last),
      .head_data_o  (fifo_data),
      .count_o      (fifo_count)
   );

   assign ram_addr_o   = {slot_q, pix_q[PIX_BITS-1:0]};
   assign ram_we_o     = 1'b0;
   assign busy_o       = (state_q != StIdle);
   assign lb_full_o    = full_q;
   assign overflow_o   = ovf_q;
   assign out_io.valid = fifo_valid;
   assign out_io.data  = fifo_data;
   assign out_io.last  = fifo_last;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Directed/randomized bench for line_buffer_reader with a slot-level reference model.
module tb_line_buffer_reader;

   localparam int unsigned DW = 8;
   localparam int unsigned PB = 9;
   localparam int unsigned LB = 2;
   localparam int Slots   = 4;
   localparam int SlotPix = 512;

   logic          clk = 1'b0;
   logic          rst, flush, line_written, start;
   logic          lb_full, overflow, busy, ram_we;
   logic [PB-1:0] line_width;
   logic [PB+LB-1:0] ram_addr;
   logic [DW-1:0] ram_q;
   logic [DW-1:0] mem [Slots*SlotPix];

   line_buffer_reader_if #(.DATA_WIDTH(DW)) out_if ();

   line_buffer_reader #(
      .DATA_WIDTH (DW),
      .PIX_BITS   (PB),
      .LINE_BITS  (LB)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .flush_i        (flush),
      .line_written_i (line_written),
      .lb_full_o      (lb_full),
      .overflow_o     (overflow),
      .start_i        (start),
      .line_width_i   (line_width),
      .busy_o         (busy),
      .ram_addr_o     (ram_addr),
      .ram_we_o       (ram_we),
      .ram_q_i        (ram_q),
      .out_io         (out_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ram_q <= mem[ram_addr];

   int n_checks = 0;
   int n_fail   = 0;
   int m_count  = 0;
   int m_slot   = 0;
   bit m_ovf    = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_lw();
      line_written = 1'b1;
      if (m_count == Slots) m_ovf = 1'b1;
      else                  m_count++;
      step();
      line_written = 1'b0;
   endtask

   task automatic start_line(input int w);
      start      = 1'b1;
      line_width = PB'(w);
      step();
      start = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush   = 1'b0;
      m_count = 0;
      m_slot  = 0;
      m_ovf   = 1'b0;
   endtask

   // Consume one line under a ready pattern; optionally pulse line_written on the last accept.
   task automatic do_line(input int w, input int mode, input bit lw_on_last);
      int          weff = (w == 0) ? SlotPix : w;
      int          idx  = 0;
      int          cyc  = 0;
      bit          done = 1'b0;
      bit          held_v = 1'b0;
      logic [DW-1:0] held_d = '0;
      while (!done && cyc < 4000) begin
         case (mode)
            0:       out_if.ready = 1'b1;
            1:       out_if.ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_if.ready = 1'($urandom_range(0, 1));
         endcase
         if (held_v) begin
            check("stall_valid", out_if.valid, 1);
            check("stall_data", out_if.data, held_d);
         end
         held_v = 1'b0;
         if (out_if.valid && out_if.ready) begin
            check("pix_data", out_if.data, mem[m_slot*SlotPix + idx]);
            check("pix_last", out_if.last, (idx == weff - 1));
            if (idx == weff - 1) begin
               done = 1'b1;
               if (lw_on_last) line_written = 1'b1;
               else            m_count--;
               m_slot = (m_slot + 1) % Slots;
            end
            idx++;
         end else if (out_if.valid) begin
            held_v = 1'b1;
            held_d = out_if.data;
         end
         step();
         line_written = 1'b0;
         cyc++;
      end
      check("line_done", done, 1);
      check("end_busy", busy, 0);
      check("end_full", lb_full, (m_count == Slots));
      check("end_ovf", overflow, m_ovf);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int i = 0; i < Slots*SlotPix; i++) mem[i] = DW'($urandom);
      rst = 1'b1; flush = 1'b0; line_written = 1'b0; start = 1'b0;
      line_width = '0; out_if.ready = 1'b0;
      repeat (3) step();

      check("rst_valid", out_if.valid, 0);
      check("rst_busy", busy, 0);
      check("rst_full", lb_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_data", out_if.data, 0);
      check("rst_last", out_if.last, 0);
      check("rst_we", ram_we, 0);
      rst = 1'b0;
      step();

      // Basic line: width 4 with a 3-cycle start-to-pixel latency.
      pulse_lw();
      out_if.ready = 1'b1;
      start_line(4);
      check("basic_c1_busy", busy, 1);
      check("basic_c1_addr", ram_addr, 0);
      check("basic_c1_valid", out_if.valid, 0);
      step();
      check("basic_c2_addr", ram_addr, 1);
      check("basic_c2_valid", out_if.valid, 0);
      step();
      check("basic_c3_valid", out_if.valid, 1);
      check("basic_c3_addr", ram_addr, 2);
      check("basic_c3_data", out_if.data, mem[0]);
      do_line(4, 0, 1'b0);

      // Backpressure pattern 1,0,0,1 on an 8-pixel line.
      pulse_lw();
      start_line(8);
      do_line(8, 1, 1'b0);

      // Wait for data, then wrap through all slots.
      do_flush();
      for (int ln = 0; ln < 5; ln++) begin
         w = $urandom_range(1, 12);
         start_line(w);
         for (int c = 0; c < 5; c++) begin
            check("wait_valid", out_if.valid, 0);
            check("wait_busy", busy, 1);
            step();
         end
         pulse_lw();
         check("wait_k1_addr", ram_addr, m_slot*SlotPix);
         check("wait_k1_valid", out_if.valid, 0);
         step();
         check("wait_k2_valid", out_if.valid, 0);
         step();
         check("wait_k3_valid", out_if.valid, 1);
         check("wait_k3_data", out_if.data, mem[m_slot*SlotPix]);
         do_line(w, 2, 1'b0);
      end

      // Fill to full; write alongside a last accept keeps the count full without overflow.
      for (int i = 0; i < Slots; i++) begin
         pulse_lw();
         check("fill_full", lb_full, (i == Slots - 1));
      end
      check("fill_ovf", overflow, 0);
      start_line(3);
      do_line(3, 0, 1'b1);
      pulse_lw();
      check("ovf_set", overflow, 1);
      check("ovf_full", lb_full, 1);
      for (int i = 0; i < Slots; i++) begin
         w = $urandom_range(1, 6);
         start_line(w);
         do_line(w, 2, 1'b0);
      end
      start_line(5);
      for (int c = 0; c < 6; c++) begin
         check("drained_valid", out_if.valid, 0);
         step();
      end
      do_flush();
      check("flush_busy", busy, 0);
      check("flush_ovf", overflow, 0);
      check("flush_full", lb_full, 0);

      // Width 0 means a full 512-pixel line.
      pulse_lw();
      start_line(0);
      do_line(0, 2, 1'b0);

      // Flush mid-line abandons the line and rewinds the read slot.
      pulse_lw();
      pulse_lw();
      out_if.ready = 1'b1;
      start_line(16);
      repeat (5) step();
      do_flush();
      check("mid_valid", out_if.valid, 0);
      check("mid_busy", busy, 0);
      check("mid_full", lb_full, 0);
      check("mid_addr", ram_addr, 0);
      start_line(4);
      for (int c = 0; c < 4; c++) begin
         check("mid_wait_valid", out_if.valid, 0);
         step();
      end
      pulse_lw();
      do_line(4, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
